lc3_modport: RTL and testbench
==============================

# lc3_modport

Multicycle LC-3 processor core for the LC-3 verification environment. It holds an instruction memory loaded through a write port, an internal data memory and an 8×16 register file. It executes a fixed LC-3 subset one instruction at a time. The data-memory bus and the register writeback are exposed for checking.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory words, indexed by address[7:0].
- `DMEM_DEPTH`, 256: data memory words, indexed by address[7:0].
- `PC_RESET`, 16'h3000: PC value after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `din_inst` in 16: instruction word to load.
- `addr_inst` in 16: instruction memory write address.
- `write_inst` in 1: writes `din_inst` to IMEM[`addr_inst[7:0]`] at the clock edge; works regardless of `reset`.
- `rd` out 1: data-memory access type; 1 = read or idle, 0 = write cycle.
- `addr` out 16: data-memory effective address.
- `din` out 16: data-memory write data.
- `dr` out 3: destination register of the last writeback.
- `dr_in` out 16: value of the last writeback.
- `complete` out 1: one-cycle pulse when an instruction retires.

## Operation
- Instruction set:
  - ADD/AND, register or imm5 form.
  - NOT.
  - LEA.
  - LD, LDR, LDI.
  - ST, STR, STI.
  - BR nzp.
  - JMP.
  - Any other opcode is a NOP.
- Offsets are sign-extended. PC-relative address = PC+1+offset. Arithmetic is mod 2^16.
- Condition codes NZP are set from the written value by ADD, AND, NOT, LEA, LD, LDR and LDI.
- BR is taken if (nzp_field & NZP) != 0. JMP sets PC = BaseR.
- FSM states, held in a 4-bit state register:
  - FETCH=0, DECODE=1, EXEC=2, IND=3, MEM=4, WB=5.
- Transitions:
  - ALU/LEA: F→D→E→WB.
  - LD/LDR: F→D→E→MEM→WB.
  - LDI: F→D→E→IND→MEM→WB.
  - ST/STR: F→D→E→MEM.
  - STI: F→D→E→IND→MEM.
  - BR/JMP/NOP: F→D→E.
- After the final state the FSM returns to FETCH. The PC updates at the end of the final state.
- Bus outputs in IND and MEM states: `addr` = effective address, `rd`=1.
  - Exception: the MEM state of a store drives `rd`=0 and `din` = SR value. DMEM is written at that cycle's closing edge.
- In all other states the bus idles: `rd`=1, `addr`=0, `din`=0.
- At the WB closing edge: RF[DR], `dr` and `dr_in` are loaded, and NZP updates. `dr` and `dr_in` hold until the next writeback.

## Timing
- Reset (asynchronous, `reset`=0) sets:
  - PC=`PC_RESET`, state=FETCH.
  - R0–R7=0, NZP=3'b010.
  - `dr`=0, `dr_in`=0, `complete`=0.
  - Bus idle.
- IMEM and DMEM contents are not reset.
- Execution begins at the first rising edge with `reset`=1.
- Cycles per instruction:
  - 3: BR, JMP, NOP.
  - 4: ALU, LEA, ST, STR.
  - 5: LD, LDR, STI.
  - 6: LDI.
- `complete` is registered: high for exactly the one cycle after the final state's edge. It coincides with the updated `dr`/`dr_in`.
- Asserting reset mid-instruction aborts that instruction. No partial register write occurs; a DMEM write occurs only if the MEM edge has already passed.
- An IMEM write to the address being fetched in the same cycle: the fetch returns the old word.

## Structure
- Shared package `lc3_pkg`:
  - opcode constants;
  - state enum;
  - NZP typedef;
  - `PC_RESET`.
- Natural sub-module: `lc3_alu`, covering ADD/AND/NOT and the address adder. The FSM, register file and memories stay in the top level.

## Test plan
- Load IMEM[0]=16'h1225 (ADD R1,R0,#5) and release reset. Required: `complete` pulses 4 cycles later; `dr`=1, `dr_in`=16'h0005, NZP=P.
- Load IMEM[1]=16'h927F (NOT R1,R1). Required: `dr`=1, `dr_in`=16'hFFFA, NZP=N.
- IMEM[2]=16'h3202 (ST R1,#2). Required: MEM cycle shows `rd`=0, `addr`=16'h3005, `din`=16'hFFFA; 4 cycles.
- IMEM[3]=16'h2401 (LD R2,#1). Required: `addr`=16'h3005, `rd`=1; then `dr`=2, `dr_in`=16'hFFFA after 5 cycles.
- After reset, IMEM[0]=16'h0402 (BRz #2). Required: taken since NZP=Z; next fetch from 16'h3003; 3 cycles; `dr`/`dr_in` unchanged.
- Pull `reset` low during the EXEC state of an ADD. Required: all outputs at reset values immediately; RF unchanged; restart fetches 16'h3000.

Source files
------------

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared opcodes, FSM state encoding, condition-code type and
//               reset PC for the multicycle LC-3 core.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    localparam logic [15:0] LC3_PC_RESET = 16'h3000;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_IND    = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5
    } state_e;

    // Bit 2 = N, bit 1 = Z, bit 0 = P
    typedef logic [2:0] nzp_t;

    function automatic nzp_t nzp_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_alu.sv
`default_nettype none
// ============================================================================
// Module      : lc3_alu
// Description : ADD/AND/NOT datapath and effective-address adder. LEA's
//               result is the PC-relative address itself.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_alu
    import lc3_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [8:0]  fld_i,      // instruction bits [8:0]
    input  logic [15:0] pc_i,       // address of the executing instruction
    input  logic [15:0] sr1_i,      // RF[IR[8:6]]
    input  logic [15:0] sr2_i,      // RF[IR[2:0]]
    output logic [15:0] result_o,
    output logic [15:0] ea_o
);

    logic [15:0] w_off9;
    logic [15:0] w_off6;
    logic [15:0] w_imm5;
    logic [15:0] w_opb;

    // Sign-extend the offset fields, pick operand B, then address and result.
    always_comb begin
        w_off9   = {{7{fld_i[8]}}, fld_i[8:0]};
        w_off6   = {{10{fld_i[5]}}, fld_i[5:0]};
        w_imm5   = {{11{fld_i[4]}}, fld_i[4:0]};
        w_opb    = fld_i[5] ? w_imm5 : sr2_i;
        ea_o     = pc_i + 16'd1 + w_off9;
        result_o = '0;

        case (op_i)
            OP_LDR, OP_STR: ea_o = sr1_i + w_off6;
            OP_JMP:         ea_o = sr1_i;
            default:        ea_o = pc_i + 16'd1 + w_off9;
        endcase

        case (op_i)
            OP_ADD:  result_o = sr1_i + w_opb;
            OP_AND:  result_o = sr1_i & w_opb;
            OP_NOT:  result_o = ~sr1_i;
            default: result_o = ea_o;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lc3_modport.sv
`default_nettype none
// ============================================================================
// Module      : lc3_modport
// Description : Multicycle LC-3 core with loadable IMEM, internal DMEM and
//               8x16 register file. Exposes the data bus and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_modport
    import lc3_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [15:0] PC_RESET   = LC3_PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din_inst,
    input  logic [15:0] addr_inst,
    input  logic        write_inst,
    output logic        rd,
    output logic [15:0] addr,
    output logic [15:0] din,
    output logic [2:0]  dr,
    output logic [15:0] dr_in,
    output logic        complete
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] res_q, res_d;
    nzp_t        nzp_q, nzp_d;
    logic [2:0]  dr_q, dr_d;
    logic [15:0] dr_in_q, dr_in_d;
    logic        complete_q, complete_d;
    logic [15:0] rf_q [8];
    logic [15:0] imem_q [IMEM_DEPTH];
    logic [15:0] dmem_q [DMEM_DEPTH];

    logic        w_rf_we;
    logic        w_dmem_we;
    logic [3:0]  w_op;
    logic        w_is_alu, w_is_load, w_is_store, w_is_ind, w_taken;
    logic [15:0] w_sr1, w_sr2, w_src, w_alu_res, w_ea, w_dmem_rdata;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr_inst[15:8];

    assign w_op       = ir_q[15:12];
    assign w_is_alu   = (w_op == OP_ADD) || (w_op == OP_AND) || (w_op == OP_NOT) || (w_op == OP_LEA);
    assign w_is_load  = (w_op == OP_LD)  || (w_op == OP_LDR) || (w_op == OP_LDI);
    assign w_is_store = (w_op == OP_ST)  || (w_op == OP_STR) || (w_op == OP_STI);
    assign w_is_ind   = (w_op == OP_LDI) || (w_op == OP_STI);
    assign w_taken    = (w_op == OP_BR)  && ((ir_q[11:9] & nzp_q) != 3'b000);

    assign w_sr1        = rf_q[ir_q[8:6]];
    assign w_sr2        = rf_q[ir_q[2:0]];
    assign w_src        = rf_q[ir_q[11:9]];
    assign w_dmem_rdata = dmem_q[ea_q[7:0]];

    lc3_alu u_alu (
        .op_i     (w_op),
        .fld_i    (ir_q[8:0]),
        .pc_i     (pc_q),
        .sr1_i    (w_sr1),
        .sr2_i    (w_sr2),
        .result_o (w_alu_res),
        .ea_o     (w_ea)
    );

    // Next-state logic: route each instruction class through its state path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (w_is_alu)                    state_d = S_WB;
                else if (w_is_ind)               state_d = S_IND;
                else if (w_is_load || w_is_store) state_d = S_MEM;
                else                             state_d = S_FETCH;
            end
            S_IND:    state_d = S_MEM;
            S_MEM:    state_d = w_is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath next values; the PC advances only at the end of the final state.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ea_d       = ea_q;
        res_d      = res_q;
        nzp_d      = nzp_q;
        dr_d       = dr_q;
        dr_in_d    = dr_in_q;
        complete_d = 1'b0;
        w_rf_we    = 1'b0;
        w_dmem_we  = 1'b0;
        case (state_q)
            S_FETCH: ir_d = imem_q[pc_q[7:0]];
            S_EXEC: begin
                res_d = w_alu_res;
                ea_d  = w_ea;
                if (!w_is_alu && !w_is_load && !w_is_store) begin
                    complete_d = 1'b1;
                    pc_d       = (w_taken || (w_op == OP_JMP)) ? w_ea : pc_q + 16'd1;
                end
            end
            S_IND: ea_d = w_dmem_rdata;
            S_MEM: begin
                if (w_is_load) begin
                    res_d = w_dmem_rdata;
                end else begin
                    w_dmem_we  = 1'b1;
                    complete_d = 1'b1;
                    pc_d       = pc_q + 16'd1;
                end
            end
            S_WB: begin
                w_rf_we    = 1'b1;
                dr_d       = ir_q[11:9];
                dr_in_d    = res_q;
                nzp_d      = nzp_of(res_q);
                complete_d = 1'b1;
                pc_d       = pc_q + 16'd1;
            end
            default: ;
        endcase
    end

    // Bus drive: address visible in IND/MEM, write strobe only in a store's MEM.
    always_comb begin
        rd   = 1'b1;
        addr = '0;
        din  = '0;
        if ((state_q == S_IND) || (state_q == S_MEM)) begin
            addr = ea_q;
            if ((state_q == S_MEM) && w_is_store) begin
                rd  = 1'b0;
                din = w_src;
            end
        end
    end

    // Architectural and control state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RESET;
            ir_q       <= '0;
            ea_q       <= '0;
            res_q      <= '0;
            nzp_q      <= 3'b010;
            dr_q       <= '0;
            dr_in_q    <= '0;
            complete_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ea_q       <= ea_d;
            res_q      <= res_d;
            nzp_q      <= nzp_d;
            dr_q       <= dr_d;
            dr_in_q    <= dr_in_d;
            complete_q <= complete_d;
            if (w_rf_we) rf_q[ir_q[11:9]] <= res_q;
        end
    end

    // Instruction load port; independent of reset so code can be loaded while held.
    always_ff @(posedge clk) begin
        if (write_inst) imem_q[addr_inst[7:0]] <= din_inst;
    end

    // Data memory write at the closing edge of a store's MEM cycle.
    always_ff @(posedge clk) begin
        if (w_dmem_we) dmem_q[ea_q[7:0]] <= w_src;
    end

    assign dr       = dr_q;
    assign dr_in    = dr_in_q;
    assign complete = complete_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_modport.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_modport
// Description : Directed and randomized checks of lc3_modport against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_modport;

    localparam int NRAND = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din_inst = '0;
    logic [15:0] addr_inst = '0;
    logic        write_inst = 1'b0;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [2:0]  dr;
    logic [15:0] dr_in;
    logic        complete;

    always #5 clk = ~clk;

    lc3_modport dut (
        .clk        (clk),
        .reset      (reset),
        .din_inst   (din_inst),
        .addr_inst  (addr_inst),
        .write_inst (write_inst),
        .rd         (rd),
        .addr       (addr),
        .din        (din),
        .dr         (dr),
        .dr_in      (dr_in),
        .complete   (complete)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  dr;
        logic [15:0] val;
        bit          st;
        logic [15:0] sa;
        logic [15:0] sd;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    logic [15:0] last_addr;

    // Instruction-level model state
    logic [15:0] m_rf [8];
    logic [15:0] m_dm [256];
    bit          m_ok [256];
    logic [15:0] m_pc;
    logic [2:0]  m_nzp;
    logic [2:0]  m_dr;
    logic [15:0] m_drin;
    logic [15:0] prog [256];
    exp_t        qexp [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [2:0] d, input logic [15:0] v,
                                input bit s, input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        e.cyc = c; e.dr = d; e.val = v; e.st = s; e.sa = a; e.sd = w;
        return e;
    endfunction

    task automatic wr_imem(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr_inst  = {8'h30, a};
        din_inst   = d;
        write_inst = 1'b1;
        @(negedge clk);
        write_inst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":complete"}, complete, 0);
        chk({tag, ":dr"}, dr, 0);
        chk({tag, ":dr_in"}, dr_in, 0);
        chk({tag, ":rd"}, rd, 1);
        chk({tag, ":addr"}, addr, 0);
        chk({tag, ":din"}, din, 0);
    endtask

    // Count edges until complete; capture any write cycle seen on the bus.
    task automatic run_instr(input string tag, input exp_t e);
        int          n = 0;
        bit          done = 0;
        bit          st_seen = 0;
        logic [15:0] sa = '0;
        logic [15:0] sd = '0;
        last_addr = '0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (complete) begin
                done = 1;
            end else begin
                if (!rd) begin
                    st_seen = 1; sa = addr; sd = din;
                end
                if (addr != 16'h0000) last_addr = addr;
            end
        end
        chk({tag, ":cycles"}, n, e.cyc);
        chk({tag, ":dr"}, dr, e.dr);
        chk({tag, ":dr_in"}, dr_in, e.val);
        chk({tag, ":store"}, st_seen, e.st);
        if (e.st) begin
            chk({tag, ":st_addr"}, sa, e.sa);
            chk({tag, ":st_data"}, sd, e.sd);
        end
    endtask

    function automatic logic [2:0] r3();
        return 3'($urandom_range(0, 7));
    endfunction

    // Execute one instruction at ISA level and return what the bus/WB should show.
    function automatic exp_t model_exec(input logic [15:0] ins);
        exp_t        e;
        logic [3:0]  op = ins[15:12];
        logic [15:0] pc1 = m_pc + 16'd1;
        logic [15:0] o9 = {{7{ins[8]}}, ins[8:0]};
        logic [15:0] o6 = {{10{ins[5]}}, ins[5:0]};
        logic [15:0] i5 = {{11{ins[4]}}, ins[4:0]};
        logic [15:0] a = m_rf[ins[8:6]];
        logic [15:0] b = ins[5] ? i5 : m_rf[ins[2:0]];
        logic [15:0] v = '0;
        logic [15:0] ea = '0;
        logic [15:0] npc = pc1;
        bit          wr = 0;
        bit          st = 0;
        e = mk(3, 0, 0, 0, 0, 0);
        case (op)
            4'h1: begin v = a + b; wr = 1; e.cyc = 4; end
            4'h5: begin v = a & b; wr = 1; e.cyc = 4; end
            4'h9: begin v = ~a;    wr = 1; e.cyc = 4; end
            4'hE: begin v = pc1 + o9; wr = 1; e.cyc = 4; end
            4'h2: begin ea = pc1 + o9; v = m_dm[ea[7:0]]; wr = 1; e.cyc = 5; end
            4'h6: begin ea = a + o6;   v = m_dm[ea[7:0]]; wr = 1; e.cyc = 5; end
            4'hA: begin
                ea = pc1 + o9; ea = m_dm[ea[7:0]]; v = m_dm[ea[7:0]]; wr = 1; e.cyc = 6;
            end
            4'h3: begin ea = pc1 + o9; st = 1; e.cyc = 4; end
            4'h7: begin ea = a + o6;   st = 1; e.cyc = 4; end
            4'hB: begin ea = pc1 + o9; ea = m_dm[ea[7:0]]; st = 1; e.cyc = 5; end
            4'h0: if ((ins[11:9] & m_nzp) != 3'b000) npc = pc1 + o9;
            4'hC: npc = a;
            default: ;
        endcase
        if (st) begin
            e.st = 1; e.sa = ea; e.sd = m_rf[ins[11:9]];
            m_dm[ea[7:0]] = m_rf[ins[11:9]];
            m_ok[ea[7:0]] = 1;
        end
        if (wr) begin
            m_rf[ins[11:9]] = v;
            m_dr = ins[11:9];
            m_drin = v;
            m_nzp = v[15] ? 3'b100 : (v == 16'h0000) ? 3'b010 : 3'b001;
        end
        m_pc = npc;
        e.dr = m_dr;
        e.val = m_drin;
        return e;
    endfunction

    // Random instruction; loads only touch locations the model has written.
    function automatic logic [15:0] gen_ins();
        logic [15:0] ins;
        logic [15:0] pc1 = m_pc + 16'd1;
        logic [15:0] t;
        logic [7:0]  idx;
        logic [5:0]  o6;
        logic [2:0]  base;
        int          k = $urandom_range(0, 12);
        ins = {4'h3, r3(), 9'($urandom)};
        case (k)
            0: ins = {4'h1, r3(), r3(), 3'b000, r3()};
            1: ins = {4'h1, r3(), r3(), 1'b1, 5'($urandom)};
            2: ins = {4'h5, r3(), r3(), 6'($urandom)};
            3: ins = {4'h9, r3(), r3(), 6'h3F};
            4: ins = {4'hE, r3(), 9'($urandom)};
            6: ins = {4'h7, r3(), r3(), 6'($urandom)};
            7, 9, 10: begin
                for (int i = 0; i < 16; i++) begin
                    idx = 8'($urandom);
                    if (m_ok[idx] && (k != 9 || m_ok[m_dm[idx][7:0]])) begin
                        t = (k == 7) ? 16'h2 : (k == 9) ? 16'hA : 16'hB;
                        ins = {t[3:0], r3(), 1'($urandom), 8'(idx - pc1[7:0])};
                        break;
                    end
                end
            end
            8: begin
                base = r3();
                o6 = 6'($urandom);
                t = m_rf[base] + {{10{o6[5]}}, o6};
                if (m_ok[t[7:0]]) ins = {4'h6, r3(), base, o6};
            end
            11: ins = {4'h0, r3(), 9'($urandom_range(0, 2))};
            12: ins = {4'hD, 12'($urandom)};
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        logic [15:0] ins;
        exp_t        e;

        // ---- Reset state and directed ALU / store / load sequence ----
        wr_imem(8'd0, 16'h1225);
        wr_imem(8'd1, 16'h927F);
        wr_imem(8'd2, 16'h3202);
        wr_imem(8'd3, 16'h2401);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        run_instr("add_imm", mk(4, 3'd1, 16'h0005, 0, 0, 0));
        run_instr("not",     mk(4, 3'd1, 16'hFFFA, 0, 0, 0));
        run_instr("st",      mk(4, 3'd1, 16'hFFFA, 1, 16'h3005, 16'hFFFA));
        run_instr("ld",      mk(5, 3'd2, 16'hFFFA, 0, 0, 0));
        chk("ld:addr", last_addr, 16'h3005);

        // ---- Branch on reset Z flag, JMP, then reset during EXEC ----
        @(negedge clk);
        reset = 1'b0;
        wr_imem(8'd0, 16'h0402);   // BRz #2
        wr_imem(8'd3, 16'h1627);   // ADD R3,R0,#7
        wr_imem(8'd4, 16'hC0C0);   // JMP R3
        wr_imem(8'd7, 16'h18E1);   // ADD R4,R3,#1
        wr_imem(8'd8, 16'h1225);   // ADD R1,R0,#5
        @(negedge clk);
        reset = 1'b1;
        run_instr("brz",   mk(3, 3'd0, 16'h0000, 0, 0, 0));
        run_instr("add_r3", mk(4, 3'd3, 16'h0007, 0, 0, 0));
        run_instr("jmp",   mk(3, 3'd3, 16'h0007, 0, 0, 0));
        run_instr("add_r4", mk(4, 3'd4, 16'h0008, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        run_instr("re_brz", mk(3, 3'd0, 16'h0000, 0, 0, 0));
        run_instr("re_add", mk(4, 3'd3, 16'h0007, 0, 0, 0));

        // ---- Randomized program against the instruction-level model ----
        for (int i = 0; i < 256; i++) begin
            prog[i] = 16'h0000;
            m_ok[i] = 0;
            m_dm[i] = '0;
        end
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_pc = 16'h3000; m_nzp = 3'b010; m_dr = '0; m_drin = '0;
        for (int i = 0; i < NRAND; i++) begin
            ins = gen_ins();
            prog[m_pc[7:0]] = ins;
            e = model_exec(ins);
            qexp.push_back(e);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) wr_imem(8'(i), prog[i]);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            e = qexp.pop_front();
            run_instr($sformatf("rnd%0d", i), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
